// File: rtl/scratch_pad_ctrl.sv
// -----------------------------------------------------------------------------
// scratch_pad_ctrl
//
// Purpose:
//   Sequences one register operation at a time on the 8008's 7-entry
//   scratch pad (A,B,C,D,E,H,L). The scratch pad has a one-hot select.
//   Supported operations:
//     - MOV  : register-to-register move
//     - INR  : increment, updates the S/Z/P flags
//     - DCR  : decrement, updates the S/Z/P flags
//     - HLRD : assembles the 14-bit H:L memory address
//   The controller drives the scratch pad's select, write-enable and
//   write-data lines from registers only. The file is level sensitive, so
//   these lines never glitch while a write is open.
//
// Handshake (valid/ready):
//   An operation transfers on a rising clk edge where op_valid && op_ready.
//   op_ready is high only in IDLE. While the controller is busy, op_valid is
//   ignored; the requester keeps op_valid and the op_* fields steady until
//   op_ready returns. Every accepted operation ends with a one-cycle done
//   pulse. An illegal operation (one that uses code M) also raises err in
//   that same done cycle and does not write the scratch pad.
//
// Ports:
//   clk, rst_n      - rising-edge clock, synchronous active-low reset
//   op_valid/ready  - operation request / controller idle
//   op_code         - 00 MOV, 01 INR, 10 DCR, 11 HLRD
//   op_dst, op_src  - register codes A=0 .. L=6, M=7 (illegal here)
//   sp_rs           - one-hot register select (code n -> bit n)
//   sp_we, sp_in    - scratch-pad write enable / write data
//   sp_out          - scratch-pad read data, combinational from sp_rs
//   flags           - {S,Z,P} from the last INR/DCR
//   hl_addr         - {H[5:0], L} from the last HLRD
//   done, err       - completion pulse / rejection pulse (with done)
// -----------------------------------------------------------------------------
module scratch_pad_ctrl #(
  parameter int DATA_W = 8,
  parameter int NREG   = 7,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [2:0]        op_dst,
  input  logic [2:0]        op_src,
  output logic [NREG-1:0]   sp_rs,
  output logic              sp_we,
  output logic [DATA_W-1:0] sp_in,
  input  logic [DATA_W-1:0] sp_out,
  output logic [2:0]        flags,
  output logic [ADDR_W-1:0] hl_addr,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_INR  = 2'b01;
  localparam logic [1:0] OP_DCR  = 2'b10;
  localparam logic [1:0] OP_HLRD = 2'b11;

  localparam logic [2:0] REG_H = 3'd5;
  localparam logic [2:0] REG_L = 3'd6;
  localparam logic [2:0] REG_M = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RD_H,
    S_RD_L,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        code_q;
  logic [2:0]        dst_q;
  logic [2:0]        src_q;
  logic [DATA_W-1:0] tmp;
  logic [DATA_W-1:0] rd_val;
  logic              req_err;

  // One-hot select for a register code. Code 7 (M) shifts out of the
  // NREG-bit field and gives an all-zero select.
  function automatic logic [NREG-1:0] onehot(input logic [2:0] code);
    onehot = NREG'(1) << code;
  endfunction

  assign op_ready = (state == S_IDLE);

  // M names memory, not a scratch-pad register. It is illegal as any
  // destination and as a MOV source. HLRD ignores dst/src.
  assign req_err = (op_code != OP_HLRD) &&
                   ((op_dst == REG_M) || ((op_code == OP_MOV) && (op_src == REG_M)));

  // Value captured in RD. The adder wraps modulo 2^DATA_W.
  always_comb begin
    rd_val = sp_out;
    case (code_q)
      OP_INR:  rd_val = sp_out + DATA_W'(1);
      OP_DCR:  rd_val = sp_out - DATA_W'(1);
      default: rd_val = sp_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      code_q  <= OP_MOV;
      dst_q   <= '0;
      src_q   <= '0;
      tmp     <= '0;
      flags   <= '0;
      hl_addr <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      sp_rs   <= '0;
      sp_we   <= 1'b0;
      sp_in   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          sp_rs <= '0;
          sp_we <= 1'b0;
          sp_in <= '0;
          if (op_valid) begin
            code_q <= op_code;
            dst_q  <= op_dst;
            src_q  <= op_src;
            if (req_err) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (op_code == OP_HLRD) begin
              state <= S_RD_H;
              sp_rs <= onehot(REG_H);
            end else begin
              // MOV reads its source. INR/DCR read the register they write.
              state <= S_RD;
              sp_rs <= onehot((op_code == OP_MOV) ? op_src : op_dst);
            end
          end
        end

        S_RD: begin
          // sp_in is loaded together with tmp, so it equals tmp for the
          // whole write cycle.
          tmp   <= rd_val;
          sp_in <= rd_val;
          sp_rs <= onehot(dst_q);
          sp_we <= 1'b1;
          state <= S_WR;
        end

        S_WR: begin
          sp_we <= 1'b0;
          sp_rs <= '0;
          sp_in <= '0;
          if (code_q == OP_INR || code_q == OP_DCR) begin
            flags <= {tmp[DATA_W-1], (tmp == '0), ~^tmp};
          end
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_RD_H: begin
          hl_addr[ADDR_W-1:DATA_W] <= sp_out[ADDR_W-DATA_W-1:0];
          sp_rs <= onehot(REG_L);
          state <= S_RD_L;
        end

        S_RD_L: begin
          hl_addr[DATA_W-1:0] <= sp_out;
          sp_rs <= '0;
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          sp_rs <= '0;
          sp_we <= 1'b0;
          sp_in <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/scratch_pad_ctrl.md
Name: scratch_pad_ctrl

Overview:
- Sequencer for the 7-entry one-hot-selected scratch-pad register file (A,B,C,D,E,H,L) of the 8008 core.
- Accepts one register operation at a time over a valid/ready handshake and drives the file's select, write-enable and write-data lines cycle by cycle.
- Operations: register-to-register move, increment/decrement with S/Z/P flags, and assembly of the 14-bit H:L memory address.
- Sits between the instruction decoder and the scratch pad.

Parameters:
- DATA_W, 8, register width; fixed at 8 for 8008 compatibility.
- NREG, 7, number of scratch-pad registers; width of the one-hot select.
- ADDR_W, 14, memory address width; H contributes ADDR_W-8 low bits.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  controller idle, request accepted when op_valid&&op_ready at clk edge
- op_code  in  2  00 MOV, 01 INR, 10 DCR, 11 HLRD
- op_dst  in  3  destination code (INR/DCR target): A=000 B=001 C=010 D=011 E=100 H=101 L=110 M=111
- op_src  in  3  source code (MOV only)
- sp_rs  out  NREG  one-hot register select to scratch pad; code n -> bit n
- sp_we  out  1  scratch-pad write enable
- sp_in  out  DATA_W  scratch-pad write data
- sp_out  in  DATA_W  scratch-pad read data (combinational from sp_rs)
- flags  out  3  {S,Z,P} from last INR/DCR
- hl_addr  out  ADDR_W  {H[5:0],L[7:0]} from last HLRD
- done  out  1  one-cycle pulse, operation complete
- err  out  1  one-cycle pulse coincident with done, operation rejected

Behaviour:
- States: IDLE, RD, WR, RD_H, RD_L, DONE. op_ready=1 only in IDLE.
- Reset (rst_n low at edge, any state incl. mid-operation): state->IDLE, tmp/flags/hl_addr/done/err -> 0; aborted op produces no done; no write after the reset edge. sp_rs=0, sp_we=0, sp_in=0 in IDLE.
- Accept in IDLE: latch op_code/op_dst/op_src. Code 111 (M) in op_dst for MOV/INR/DCR, or in op_src for MOV -> go straight to DONE with err=1. sp_we never asserted.
- MOV: RD drives sp_rs=onehot(src), sp_we=0, tmp<=sp_out. WR drives sp_rs=onehot(dst), sp_we=1, sp_in=tmp. Then DONE. src==dst is legal and rewrites the same value.
- INR/DCR: RD selects dst, tmp<=sp_out+1 / sp_out-1, modulo 2^8 (FF+1=00, 00-1=FF). WR writes tmp to dst. At WR->DONE, flags<= {tmp[7], tmp==0, ~^tmp} (P=1 on even parity). Flags unchanged by MOV, HLRD and errored ops.
- HLRD: RD_H selects bit5, hl_addr[13:8]<=sp_out[5:0]. RD_L selects bit6, hl_addr[7:0]<=sp_out. Then DONE. sp_we=0 throughout.
- DONE: done=1 for exactly one cycle, returns to IDLE. Next op accepted at the following edge.
- Latency from accepting edge to done high: MOV/INR/DCR/HLRD 3 cycles; error 1 cycle. Throughput: one op per 4 cycles back-to-back.
- sp_rs and sp_in are stable for the whole cycle sp_we is high; decoded from registered state/tmp only. No glitch on the level-sensitive file.
- op_valid while busy is ignored; requester holds it until op_ready.

Test Plan:
- Reset, then preload B=0x5A via MOV from A=0x5A; MOV C,B -> WR cycle sp_rs=0000100, sp_in=0x5A, sp_we=1; done 3 cycles after accept; C reads 0x5A.
- D=0xFF, INR D -> D=0x00, flags={0,1,1}. Then DCR D -> D=0xFF, flags={1,0,1}.
- E=0x06, DCR E -> E=0x05, flags={0,0,1}. E=0x08, INR E -> E=0x09, flags={0,0,1}. E=0x07, INR E -> E=0x08, flags={0,0,0}.
- H=0xC3, L=0x7E, HLRD -> hl_addr=0x037E; hl_addr then holds through a following MOV.
- MOV M,A (dst=111) -> done and err together 1 cycle after accept; sp_we never high; flags and registers unchanged.
- Pull rst_n low during WR of MOV B,A -> no done; sp_we low after the reset edge; op_ready=1; next INR A completes normally.
